// File: rtl/neuron_accumulator.sv
// Sums NUM_INPUTS signed-magnitude Q5.10 products plus a bias in a Q15.10 accumulator,
// then applies optional ReLU and saturation and returns one activation per valid/ready handshake.
module neuron_accumulator #(
  parameter int NUM_INPUTS = 16,
  parameter bit RELU       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        prod_valid,
  input  logic [15:0] product,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] neuron_out,
  output logic        overflow
);

  localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t             state;
  logic signed [25:0] acc;
  logic [CW-1:0]      count;

  logic signed [25:0] sum;
  logic [25:0]        mag_full;
  logic [15:0]        result;
  logic               result_ov;

  function automatic logic signed [25:0] sm2tc(input logic [15:0] v);
    logic signed [25:0] m;
    m = {11'd0, v[14:0]};
    return v[15] ? -m : m;
  endfunction

  // The result is formed from the sum that includes the product arriving this cycle,
  // so it can be registered on the same edge as the final product.
  always_comb begin
    sum       = acc + sm2tc(product);
    mag_full  = sum[25] ? 26'(-sum) : 26'(sum);
    result    = 16'h0000;
    result_ov = 1'b0;
    if (RELU && sum[25]) begin
      result    = 16'h0000;
      result_ov = 1'b0;
    end else if (mag_full > 26'h0007FFF) begin
      result    = {sum[25], 15'h7FFF};
      result_ov = 1'b1;
    end else begin
      result    = {sum[25] && (mag_full != 26'd0), mag_full[14:0]};
      result_ov = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      neuron_out <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= sm2tc(bias);
            count <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc   <= sum;
            count <= count + 1'b1;
            if (count == LAST) begin
              state      <= OUTPUT;
              out_valid  <= 1'b1;
              neuron_out <= result;
              overflow   <= result_ov;
            end
          end
        end
        OUTPUT: begin
          // neuron_out and overflow are left untouched so they persist past the handshake.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Downstream consumer of the bit-serial multiplier stage. Sums NUM_INPUTS signed-magnitude Q5.10 products plus a per-neuron bias into a wide two's-complement accumulator, applies optional ReLU, saturates to signed-magnitude Q5.10, and presents one neuron activation per valid/ready handshake. One instance serves one neuron at a time; the layer controller pulses `prod_valid` as each multiplier result settles.

## Interface
- NUM_INPUTS, 16, products summed per neuron; legal range 1..512
- RELU, 1, 1 = negative sums clamp to zero; 0 = pass signed result
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low
- start  in  1  begin a neuron; sampled only in IDLE
- bias  in  16  signed-magnitude Q5.10 (bit15 sign, [14:10] integer, [9:0] fraction), sampled with start
- prod_valid  in  1  product is valid this cycle
- product  in  16  signed-magnitude Q5.10 multiplier result
- busy  out  1  high in ACCUM and OUTPUT
- out_valid  out  1  neuron_out is valid
- out_ready  in  1  consumer accepts neuron_out
- neuron_out  out  16  signed-magnitude Q5.10 activation
- overflow  out  1  final sum saturated; valid with out_valid

## Operation
- States: IDLE, ACCUM, OUTPUT.
- IDLE: start=1 -> acc <= sm2tc(bias), count <= 0, go ACCUM. prod_valid ignored.
- ACCUM: prod_valid=1 -> acc <= acc + sm2tc(product), count++. The product with count==NUM_INPUTS-1 goes to OUTPUT and registers the result. start ignored.
- OUTPUT: hold neuron_out/overflow stable; out_valid && out_ready -> IDLE. start and prod_valid ignored.
- sm2tc: magnitude [14:0] zero-extended to 26 bits, negated if bit15=1. Negative zero (0x8000) equals 0.
- Accumulator: 26-bit two's complement, Q15.10. It cannot overflow for NUM_INPUTS<=512.
- Result formation from the final sum S:
  - RELU=1 and S<0 -> 0x0000, overflow=0.
  - Otherwise mag=|S|. If mag>0x7FFF -> mag=0x7FFF, overflow=1.
  - neuron_out={sign,mag[14:0]}. sign is forced to 0 when mag==0, so negative zero is never emitted.
- Fraction bits pass unchanged; no rounding.

## Timing
- Reset (reset=0 at a clock edge) affects state, acc, count and outputs:
  - State -> IDLE; acc and count -> 0.
  - busy, out_valid, overflow -> 0; neuron_out -> 0x0000.
  - A reset mid-ACCUM or mid-OUTPUT aborts the neuron; no partial result is emitted.
- start accepted at edge N -> busy=1 from N+1.
- prod_valid may be asserted every cycle (back-to-back) or sparsely, e.g. one pulse per 16-cycle multiply.
- Last product at edge M -> out_valid=1, neuron_out and overflow valid from M+1. Latency is one cycle after the final product.
- Handshake completes at edge K (out_valid && out_ready) -> out_valid=0 and busy=0 from K+1.
  - The earliest next start is sampled at K+1.
- neuron_out and overflow keep their last values after the handshake, until the next result is registered or a reset.
- out_ready is ignored outside OUTPUT.
- NUM_INPUTS=1: a single product moves ACCUM to OUTPUT directly.

## Test plan
- NUM_INPUTS=4, RELU=1, bias=0x0400; products 0x0800, 0x8400, 0x0200, 0x0000 -> neuron_out=0x0A00 (2.5), overflow=0, out_valid one cycle after the 4th prod_valid.
- ReLU behaviour, products 4x 0x0400:
  - bias=0x9400, RELU=1 -> 0x0000.
  - bias=0x9400, RELU=0 -> 0x8400.
  - bias=0x8C00 -> 0x0400.
- Saturation: bias=0x7FFF, products 4x 0x7FFF -> neuron_out=0x7FFF, overflow=1. With RELU=0 and all inputs 0xFFFF -> 0xFFFF, overflow=1.
- Backpressure: out_ready=0 for 5 cycles in OUTPUT, with start and prod_valid pulsed meanwhile -> out_valid, neuron_out and overflow stable, busy=1. out_ready=1 -> out_valid=0 and busy=0 next cycle.
- Reset mid-ACCUM after 2 of 4 products -> all outputs 0 next cycle, no out_valid. A following neuron with bias=0x0000 and products 4x 0x0100 -> 0x0400.
- Negative zero: bias=0x8000, products 0x8000, 0x0000, 0x8000, 0x0000 -> neuron_out=0x0000 with RELU=0 and with RELU=1.
